// File: rtl/dbf_fine_apod.sv
// ---------------------------------------------------------------------------
// dbf_fine_apod
// Per-channel digital beamformer stage that sits behind the coarse-delay
// block. Each accepted sample is linearly interpolated with the previous
// accepted sample using a fractional delay looked up per focal zone, then
// weighted by the apodisation coefficient and passed to the beam summer.
//
// Ports:
//   clk            system clock
//   rst_n          synchronous reset, active HIGH despite the name
//   start          receive window active; dropping it flushes the channel
//   tx_en          transmit active, input samples are ignored while high
//   fine_din       signed coarse-delayed sample
//   fine_din_valid qualifier for fine_din
//   apo_din        signed apodisation weight taken with the accepted sample
//   lut_addr       fine-delay LUT write address
//   lut_wdata      fraction written into the LUT
//   lut_we         LUT write enable (allowed at any time)
//   dout           signed interpolated and apodised sample, zero when idle
//   dout_valid     qualifier for dout, three cycles after the accepted sample
// ---------------------------------------------------------------------------
module dbf_fine_apod #(
    parameter int INPUT_WD = 14,
    parameter int FRAC_WD  = 4,
    parameter int APO_WD   = 16,
    parameter int ADDR_WD  = 8,
    parameter int ZONE_LEN = 64,
    parameter int OUT_WD   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       tx_en,
    input  logic signed [INPUT_WD-1:0] fine_din,
    input  logic                       fine_din_valid,
    input  logic signed [APO_WD-1:0]   apo_din,
    input  logic [ADDR_WD-1:0]         lut_addr,
    input  logic [FRAC_WD-1:0]         lut_wdata,
    input  logic                       lut_we,
    output logic signed [OUT_WD-1:0]   dout,
    output logic                       dout_valid
);

    localparam int DEPTH    = 1 << ADDR_WD;
    localparam int DIFF_WD  = INPUT_WD + 1;
    localparam int PROD_WD  = DIFF_WD + FRAC_WD + 1;
    localparam int MUL_WD   = DIFF_WD + APO_WD;
    localparam int CNT_WD   = (ZONE_LEN > 1) ? $clog2(ZONE_LEN) : 1;
    localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(ZONE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    state_t                     state_q, state_d;
    logic signed [INPUT_WD-1:0] x_prev_q, x_prev_d;
    logic [CNT_WD-1:0]          zone_cnt_q, zone_cnt_d;
    logic [ADDR_WD-1:0]         zone_addr_q, zone_addr_d;

    logic                       s1_valid_q, s1_valid_d;
    logic signed [INPUT_WD-1:0] s1_x_q, s1_x_d;
    logic signed [DIFF_WD-1:0]  s1_diff_q, s1_diff_d;
    logic [FRAC_WD-1:0]         s1_frac_q, s1_frac_d;
    logic signed [APO_WD-1:0]   s1_apo_q, s1_apo_d;

    logic                       s2_valid_q, s2_valid_d;
    logic signed [DIFF_WD-1:0]  s2_interp_q, s2_interp_d;
    logic signed [APO_WD-1:0]   s2_apo_q, s2_apo_d;

    logic                       dout_valid_q, dout_valid_d;
    logic signed [OUT_WD-1:0]   dout_q, dout_d;

    logic [FRAC_WD-1:0]         lut_q [DEPTH];
    logic [FRAC_WD-1:0]         lut_d [DEPTH];

    logic                       acc;
    logic [FRAC_WD-1:0]         frac_rd;
    logic signed [DIFF_WD-1:0]  diff_calc;
    logic signed [PROD_WD-1:0]  diff_ext;
    logic signed [PROD_WD-1:0]  frac_ext;
    logic signed [PROD_WD-1:0]  prod;
    logic signed [PROD_WD-1:0]  prod_shift;
    logic signed [DIFF_WD-1:0]  interp_calc;
    logic signed [MUL_WD-1:0]   interp_ext;
    logic signed [MUL_WD-1:0]   apo_ext;
    logic signed [MUL_WD-1:0]   mul_full;

    // LUT write port; the register array is deliberately left out of reset
    always_comb begin
        lut_d = lut_q;
        if (lut_we) begin
            lut_d[lut_addr] = lut_wdata;
        end
    end

    always_ff @(posedge clk) begin
        lut_q <= lut_d;
    end

    // Datapath arithmetic. The fraction is zero-extended so the multiply
    // stays signed; the arithmetic shift floors toward minus infinity, and
    // the interpolated value always lies between the two samples so the
    // low DIFF_WD bits hold it exactly.
    always_comb begin
        acc         = start & ~tx_en & fine_din_valid;
        frac_rd     = lut_q[zone_addr_q];
        diff_calc   = {x_prev_q[INPUT_WD-1], x_prev_q} - {fine_din[INPUT_WD-1], fine_din};
        diff_ext    = {{(FRAC_WD + 1){s1_diff_q[DIFF_WD-1]}}, s1_diff_q};
        frac_ext    = {{(DIFF_WD + 1){1'b0}}, s1_frac_q};
        prod        = diff_ext * frac_ext;
        prod_shift  = prod >>> FRAC_WD;
        interp_calc = prod_shift[DIFF_WD-1:0] + {s1_x_q[INPUT_WD-1], s1_x_q};
        interp_ext  = {{APO_WD{s2_interp_q[DIFF_WD-1]}}, s2_interp_q};
        apo_ext     = {{DIFF_WD{s2_apo_q[APO_WD-1]}}, s2_apo_q};
        mul_full    = interp_ext * apo_ext;
    end

    // Control and pipeline next-state. The zone counter advances on every
    // accepted sample (the primed one included) and bumps the zone address
    // on wrap, so sample k reads the fraction of zone k / ZONE_LEN. Dropping
    // start overrides everything and flushes the in-flight samples.
    always_comb begin
        state_d      = state_q;
        x_prev_d     = x_prev_q;
        zone_cnt_d   = zone_cnt_q;
        zone_addr_d  = zone_addr_q;
        s1_valid_d   = 1'b0;
        s1_x_d       = s1_x_q;
        s1_diff_d    = s1_diff_q;
        s1_frac_d    = s1_frac_q;
        s1_apo_d     = s1_apo_q;
        s2_valid_d   = s1_valid_q;
        s2_interp_d  = interp_calc;
        s2_apo_d     = s1_apo_q;
        dout_valid_d = s2_valid_q;
        dout_d       = s2_valid_q ? OUT_WD'(mul_full) : '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                if (acc) begin
                    x_prev_d   = fine_din;
                    zone_cnt_d = zone_cnt_q + 1'b1;
                    if (zone_cnt_q == CNT_LAST) begin
                        zone_addr_d = zone_addr_q + 1'b1;
                    end
                    state_d = RUN;
                end
            end
            RUN: begin
                if (acc) begin
                    s1_valid_d = 1'b1;
                    s1_x_d     = fine_din;
                    s1_diff_d  = diff_calc;
                    s1_frac_d  = frac_rd;
                    s1_apo_d   = apo_din;
                    x_prev_d   = fine_din;
                    zone_cnt_d = zone_cnt_q + 1'b1;
                    if (zone_cnt_q == CNT_LAST) begin
                        zone_addr_d = zone_addr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!start) begin
            state_d      = IDLE;
            zone_cnt_d   = '0;
            zone_addr_d  = '0;
            s1_valid_d   = 1'b0;
            s2_valid_d   = 1'b0;
            dout_valid_d = 1'b0;
            dout_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= IDLE;
            x_prev_q     <= '0;
            zone_cnt_q   <= '0;
            zone_addr_q  <= '0;
            s1_valid_q   <= 1'b0;
            s1_x_q       <= '0;
            s1_diff_q    <= '0;
            s1_frac_q    <= '0;
            s1_apo_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_interp_q  <= '0;
            s2_apo_q     <= '0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            state_q      <= state_d;
            x_prev_q     <= x_prev_d;
            zone_cnt_q   <= zone_cnt_d;
            zone_addr_q  <= zone_addr_d;
            s1_valid_q   <= s1_valid_d;
            s1_x_q       <= s1_x_d;
            s1_diff_q    <= s1_diff_d;
            s1_frac_q    <= s1_frac_d;
            s1_apo_q     <= s1_apo_d;
            s2_valid_q   <= s2_valid_d;
            s2_interp_q  <= s2_interp_d;
            s2_apo_q     <= s2_apo_d;
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_dbf_fine_apod.sv
// ---------------------------------------------------------------------------
// tb_dbf_fine_apod
// Directed bench for the fine-delay / apodisation stage. The design runs
// with four samples per focal zone so zone changes show up quickly. Each
// vector row is one clock cycle: inputs are driven on the falling edge and
// the registered outputs visible in that same cycle are compared against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_dbf_fine_apod;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               tx_en;
    logic signed [13:0] fine_din;
    logic               fine_din_valid;
    logic signed [15:0] apo_din;
    logic [7:0]         lut_addr;
    logic [3:0]         lut_wdata;
    logic               lut_we;
    logic signed [31:0] dout;
    logic               dout_valid;

    int compared;
    int mismatched;

    typedef struct {
        logic               rst;
        logic               start;
        logic               tx_en;
        logic               valid;
        logic signed [13:0] din;
        logic signed [15:0] apo;
        logic               we;
        logic [7:0]         addr;
        logic [3:0]         wdata;
        logic               exp_valid;
        logic signed [31:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    dbf_fine_apod #(
        .ZONE_LEN(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .tx_en         (tx_en),
        .fine_din      (fine_din),
        .fine_din_valid(fine_din_valid),
        .apo_din       (apo_din),
        .lut_addr      (lut_addr),
        .lut_wdata     (lut_wdata),
        .lut_we        (lut_we),
        .dout          (dout),
        .dout_valid    (dout_valid)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Builds one cycle's record from plain integers
    function automatic vec_t makeVec(input int rst, input int st, input int tx, input int vld,
                                     input int din, input int apo, input int we, input int addr,
                                     input int wd, input int ev, input int ed);
        vec_t v;
        v.rst       = (rst != 0);
        v.start     = (st != 0);
        v.tx_en     = (tx != 0);
        v.valid     = (vld != 0);
        v.din       = 14'(din);
        v.apo       = 16'(apo);
        v.we        = (we != 0);
        v.addr      = 8'(addr);
        v.wdata     = 4'(wd);
        v.exp_valid = (ev != 0);
        v.exp_dout  = 32'(ed);
        return v;
    endfunction

    // Drives one cycle's inputs on the falling edge
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst_n          = v.rst;
        start          = v.start;
        tx_en          = v.tx_en;
        fine_din_valid = v.valid;
        fine_din       = v.din;
        apo_din        = v.apo;
        lut_we         = v.we;
        lut_addr       = v.addr;
        lut_wdata      = v.wdata;
    endtask

    // Compares the registered outputs of the current cycle
    task automatic checkOutput(input string name, input logic ev, input logic signed [31:0] ed);
        compared++;
        if (dout_valid !== ev) begin
            mismatched++;
            $display("[TB] FAIL %s dout_valid: got %0b expected %0b", name, dout_valid, ev);
        end
        compared++;
        if (dout !== ed) begin
            mismatched++;
            $display("[TB] FAIL %s dout: got %0d expected %0d", name, dout, ed);
        end
    endtask

    // One hand-written cycle without LUT traffic
    task automatic cycleStep(input int rst, input int st, input int tx, input int vld,
                             input int din, input int apo, input int ev, input int ed,
                             input string name);
        vec_t v;
        v = makeVec(rst, st, tx, vld, din, apo, 0, 0, 0, ev, ed);
        applyStimulus(v);
        checkOutput(name, v.exp_valid, v.exp_dout);
    endtask

    // LUT write while the receive window is closed
    task automatic writeLut(input int addr, input int data);
        applyStimulus(makeVec(0, 0, 0, 0, 0, 0, 1, addr, data, 0, 0));
        checkOutput("lut_idle", 1'b0, 32'sd0);
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        rst_n          = 1'b1;
        start          = 1'b0;
        tx_en          = 1'b0;
        fine_din_valid = 1'b0;
        fine_din       = '0;
        apo_din        = '0;
        lut_we         = 1'b0;
        lut_addr       = '0;
        lut_wdata      = '0;

        //                     rst st tx  v    din     apo  we ad wd  ev  ed
        // reset and LUT setup
        vecs.push_back(makeVec(1, 0, 0, 0,     0,      0, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(1, 0, 0, 0,     0,      0, 1, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 0, 0, 0,     0,      0, 1, 1, 8, 0, 0));
        // frac 0: 100 primes, 200/300 pass through three cycles later
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 1,   100,      1, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 1,   200,      1, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 1,   300,      1, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 1, 200));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 1, 300));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 0, 0, 0,     0,      0, 0, 0, 0, 0, 0));
        // frac 8/16: midpoint of 100 and 200
        vecs.push_back(makeVec(0, 0, 0, 0,     0,      0, 1, 0, 8, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 1,   100,      1, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 1,   200,      1, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 1, 150));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 0, 0));
        // frac 1/16 on 0 -> 1: floor(1 - 1/16) = 0
        vecs.push_back(makeVec(0, 0, 0, 0,     0,      0, 1, 0, 1, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 1,     0,      1, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 1,     1,      1, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 1, 0));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 0, 0));
        // full-scale extremes with frac 15, then tx_en and valid gaps
        vecs.push_back(makeVec(0, 0, 0, 0,     0,      0, 1, 0, 15, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 1,  8191, -32768, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 1, -8192, -32768, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 1, 1,     5,      1, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 1, -234848256));
        vecs.push_back(makeVec(0, 1, 0, 1,     0,      1, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 1, 1,   999,      1, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 1,    16,      1, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 1, -7680));
        vecs.push_back(makeVec(0, 1, 0, 1,    32,      1, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 1, 1));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 0, 0));
        vecs.push_back(makeVec(0, 1, 0, 0,     0,      0, 0, 0, 0, 1, 24));
        vecs.push_back(makeVec(0, 0, 0, 0,     0,      0, 0, 0, 0, 0, 0));

        $display("[TB] applying %0d table vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_dout);
        end

        // Ramp across zone boundaries: zone 0 passes samples through,
        // zones 1 and 2 sit half a sample back (sample minus 8).
        writeLut(0, 0);
        writeLut(1, 8);
        writeLut(2, 8);
        cycleStep(0, 1, 0, 0, 0, 0, 0, 0, "ramp_arm");
        for (int c = 0; c < 16; c++) begin
            int k;
            int ev;
            int ed;
            k  = c - 3;
            ev = (k >= 1 && k < 12) ? 1 : 0;
            ed = (ev == 0) ? 0 : ((k < 4) ? 16 * k : 16 * k - 8);
            cycleStep(0, 1, 0, (c < 12) ? 1 : 0, 16 * c, 1, ev, ed, $sformatf("ramp%0d", c));
        end
        cycleStep(0, 0, 0, 0, 0, 0, 0, 0, "ramp_close");

        // Drop start mid-stream after zone 1 is reached, then restart:
        // the restart must prime again and read zone 0 (frac 4).
        writeLut(0, 4);
        writeLut(1, 0);
        cycleStep(0, 1, 0, 0,    0, 0, 0,    0, "drop_arm");
        cycleStep(0, 1, 0, 1,  100, 1, 0,    0, "drop_c0");
        cycleStep(0, 1, 0, 1,  200, 1, 0,    0, "drop_c1");
        cycleStep(0, 1, 0, 1,  300, 1, 0,    0, "drop_c2");
        cycleStep(0, 1, 0, 1,  400, 1, 0,    0, "drop_c3");
        cycleStep(0, 1, 0, 1,  500, 1, 1,  175, "drop_c4");
        cycleStep(0, 0, 0, 0,    0, 0, 1,  275, "drop_c5");
        cycleStep(0, 0, 0, 0,    0, 0, 0,    0, "drop_flush0");
        cycleStep(0, 0, 0, 0,    0, 0, 0,    0, "drop_flush1");
        cycleStep(0, 1, 0, 0,    0, 0, 0,    0, "restart_arm");
        cycleStep(0, 1, 0, 1, 1000, 1, 0,    0, "restart_prime");
        cycleStep(0, 1, 0, 1, 2000, 1, 0,    0, "restart_s1");
        cycleStep(0, 1, 0, 0,    0, 0, 0,    0, "restart_gap0");
        cycleStep(0, 1, 0, 0,    0, 0, 0,    0, "restart_gap1");
        cycleStep(0, 1, 0, 0,    0, 0, 1, 1750, "restart_out");
        cycleStep(0, 1, 0, 0,    0, 0, 0,    0, "restart_idle");
        cycleStep(0, 0, 0, 0,    0, 0, 0,    0, "restart_close");

        // Two-cycle reset mid-stream with start held high: outputs clear,
        // in-flight samples vanish and the stream re-primes afterwards.
        writeLut(0, 8);
        cycleStep(0, 1, 0, 0,   0, 0, 0,   0, "rst_arm");
        cycleStep(0, 1, 0, 1, 100, 1, 0,   0, "rst_c0");
        cycleStep(0, 1, 0, 1, 200, 1, 0,   0, "rst_c1");
        cycleStep(0, 1, 0, 1, 300, 1, 0,   0, "rst_c2");
        cycleStep(1, 1, 0, 1, 400, 1, 0,   0, "rst_c3");
        cycleStep(1, 1, 0, 0,   0, 0, 0,   0, "rst_c4");
        cycleStep(0, 1, 0, 0,   0, 0, 0,   0, "rst_c5");
        cycleStep(0, 1, 0, 1, 700, 1, 0,   0, "rst_prime");
        cycleStep(0, 1, 0, 1, 900, 1, 0,   0, "rst_s1");
        cycleStep(0, 1, 0, 0,   0, 0, 0,   0, "rst_gap0");
        cycleStep(0, 1, 0, 0,   0, 0, 0,   0, "rst_gap1");
        cycleStep(0, 1, 0, 0,   0, 0, 1, 800, "rst_out");
        cycleStep(0, 1, 0, 0,   0, 0, 0,   0, "rst_idle");
        cycleStep(0, 0, 0, 0,   0, 0, 0,   0, "rst_close");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
